// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles one 32-bit little-endian instruction from four
// byte reads on the shared memory port and presents it to the decoder until consumed.
module if_fetch #(
    parameter int unsigned                  ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  stall,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  mem_grant,
    input  logic [7:0]            mem_din,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  hit,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           inst
);

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned RECV_W  = 2;
    localparam int unsigned BUF_W   = 24;
    localparam int unsigned INST_W  = 32;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                  state,     state_n;
    logic [ADDR_WIDTH-1:0]   fetch_pc,  fetch_pc_n;
    logic [CNT_W-1:0]        issue_cnt, issue_cnt_n;
    logic [RECV_W-1:0]       recv_cnt,  recv_cnt_n;
    logic                    pending,   pending_n;
    logic [BUF_W-1:0]        buffer,    buffer_n;
    logic                    hit_n;
    logic [ADDR_WIDTH-1:0]   pc_n;
    logic [INST_W-1:0]       inst_n;
    logic                    issue;

    // Byte address of the next read; issue_cnt reaches 4 only while the last byte returns.
    assign mem_a = fetch_pc + ADDR_WIDTH'(issue_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pending   <= 1'b0;
            buffer    <= '0;
            hit       <= 1'b0;
            pc        <= '0;
            inst      <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            issue_cnt <= issue_cnt_n;
            recv_cnt  <= recv_cnt_n;
            pending   <= pending_n;
            buffer    <= buffer_n;
            hit       <= hit_n;
            pc        <= pc_n;
            inst      <= inst_n;
        end
    end

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        issue_cnt_n = issue_cnt;
        recv_cnt_n  = recv_cnt;
        pending_n   = pending;
        buffer_n    = buffer;
        hit_n       = hit;
        pc_n        = pc;
        inst_n      = inst;
        issue       = 1'b0;

        if (rdy) begin
            if (jump_en) begin
                // Redirect wins over everything; clearing pending drops the byte in flight.
                state_n     = FETCH;
                fetch_pc_n  = jump_addr;
                issue_cnt_n = '0;
                recv_cnt_n  = '0;
                pending_n   = 1'b0;
                hit_n       = 1'b0;
            end else if (state == FETCH) begin
                issue       = mem_grant && (issue_cnt < CNT_W'(4));
                issue_cnt_n = issue_cnt + CNT_W'(issue);
                pending_n   = issue;
                if (pending) begin
                    if (recv_cnt == RECV_W'(3)) begin
                        inst_n      = {mem_din, buffer};
                        pc_n        = fetch_pc;
                        hit_n       = 1'b1;
                        state_n     = HOLD;
                        issue_cnt_n = '0;
                        recv_cnt_n  = '0;
                        pending_n   = 1'b0;
                    end else begin
                        case (recv_cnt)
                            RECV_W'(0): buffer_n[7:0]   = mem_din;
                            RECV_W'(1): buffer_n[15:8]  = mem_din;
                            default:    buffer_n[23:16] = mem_din;
                        endcase
                        recv_cnt_n = recv_cnt + RECV_W'(1);
                    end
                end
            end else begin
                if (!stall) begin
                    hit_n      = 1'b0;
                    fetch_pc_n = pc + ADDR_WIDTH'(4);
                    state_n    = FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes expected instructions into a scoreboard,
// a negedge monitor pops and checks each newly presented instruction.
module tb_if_fetch;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n, rdy, stall, jump_en, mem_grant;
    logic [AW-1:0] jump_addr, mem_a, pc;
    logic [7:0]    mem_din = 8'h00;
    logic          hit;
    logic [31:0]   inst;

    logic [7:0]    mem [0:1023];
    int            cmp_cnt = 0;
    int            err_cnt = 0;
    int            cyc = 0;
    int            t;
    logic          hit_q = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    if_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .stall(stall),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_grant(mem_grant), .mem_din(mem_din), .mem_a(mem_a),
        .hit(hit), .pc(pc), .inst(inst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with 1-cycle latency; stalls along with the pipeline when rdy=0.
    always @(posedge clk) if (rdy) mem_din <= mem[mem_a[9:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] w, input int c);
        exp_t e;
        e.pc = p; e.inst = w; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        mem[a]   = w[7:0];
        mem[a+1] = w[15:8];
        mem[a+2] = w[23:16];
        mem[a+3] = w[31:24];
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: each new presentation of an instruction must match the scoreboard head.
    always @(negedge clk) begin
        if (hit && !hit_q) begin
            if (sb.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_hit @cyc %0d: pc %h inst %h, none expected", cyc, pc, inst);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_inst", inst, e.inst);
                chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        hit_q = hit;
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        set_word(32'h000, 32'h00100513);
        set_word(32'h004, 32'h00200593);
        set_word(32'h008, 32'h00300613);
        set_word(32'h00C, 32'hdeadbeef);
        set_word(32'h100, 32'h0badf00d);
        set_word(32'h104, 32'h12345678);
        set_word(32'h200, 32'hcafe0001);
        set_word(32'h300, 32'h00a00093);
        set_word(32'h304, 32'h11223344);

        rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; jump_en = 1'b0;
        jump_addr = '0; mem_grant = 1'b1;
        tick(2);
        chk("reset_hit", 32'(hit), 32'h0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_mem_a", mem_a, 32'h0);

        // First fetch: bytes addressed in cycles 0..3, hit in cycle 5.
        rst_n = 1'b1;
        push(32'h0, 32'h00100513, cyc + 5);
        for (int i = 0; i < 4; i++) begin
            chk("first_mem_a", mem_a, 32'(i));
            tick(1);
        end
        tick(1);
        // Stall for three cycles while presenting.
        stall = 1'b1;
        chk("stall_hit", 32'(hit), 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_hit", 32'(hit), 32'h1);
            chk("stall_pc", pc, 32'h0);
            chk("stall_inst", inst, 32'h00100513);
        end
        stall = 1'b0;
        tick(1);
        chk("consume_hit", 32'(hit), 32'h0);
        chk("consume_mem_a", mem_a, 32'h4);
        push(32'h4, 32'h00200593, cyc + 5);
        tick(6);

        // Grant loss on bytes 1 and 2: two-cycle delay, same byte re-addressed.
        push(32'h8, 32'h00300613, cyc + 7);
        chk("grant_mem_a0", mem_a, 32'h8);
        tick(1);
        chk("grant_mem_a1", mem_a, 32'h9);
        mem_grant = 1'b0; tick(1);
        chk("grant_hold1", mem_a, 32'h9);
        mem_grant = 1'b1; tick(1);
        chk("grant_mem_a2", mem_a, 32'hA);
        mem_grant = 1'b0; tick(1);
        chk("grant_hold2", mem_a, 32'hA);
        mem_grant = 1'b1; tick(4);

        // Redirect with two bytes of the 0xC fetch captured.
        tick(3);
        jump_en = 1'b1; jump_addr = 32'h100;
        tick(1);
        jump_en = 1'b0;
        chk("jump_mid_hit", 32'(hit), 32'h0);
        chk("jump_mid_mem_a", mem_a, 32'h100);
        push(32'h100, 32'h0badf00d, cyc + 5);
        tick(6);

        // Redirect on the edge of the 4th byte of the 0x104 fetch.
        tick(4);
        jump_en = 1'b1; jump_addr = 32'h200;
        tick(1);
        jump_en = 1'b0;
        chk("jump_last_hit", 32'(hit), 32'h0);
        chk("jump_last_mem_a", mem_a, 32'h200);
        push(32'h200, 32'hcafe0001, cyc + 5);
        tick(5);

        // Redirect while holding under stall.
        stall = 1'b1;
        tick(1);
        chk("hold_hit", 32'(hit), 32'h1);
        chk("hold_pc", pc, 32'h200);
        jump_en = 1'b1; jump_addr = 32'h300;
        tick(1);
        jump_en = 1'b0; stall = 1'b0;
        chk("jump_hold_hit", 32'(hit), 32'h0);
        chk("jump_hold_mem_a", mem_a, 32'h300);
        push(32'h300, 32'h00a00093, cyc + 9);

        // rdy low for four cycles mid-fetch: everything freezes.
        tick(2);
        rdy = 1'b0;
        chk("rdy_mem_a", mem_a, 32'h302);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rdy_frozen_mem_a", mem_a, 32'h302);
        end
        tick(1);
        rdy = 1'b1;
        chk("rdy_resume_mem_a", mem_a, 32'h302);
        tick(4);

        // Reset mid-fetch of 0x304, with rdy low to show reset ignores it.
        tick(2);
        rst_n = 1'b0; rdy = 1'b0;
        tick(1);
        chk("midrst_hit", 32'(hit), 32'h0);
        chk("midrst_mem_a", mem_a, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_inst", inst, 32'h0);
        rst_n = 1'b1; rdy = 1'b1;
        push(32'h0, 32'h00100513, cyc + 5);
        tick(6);

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            tick(1);
            t++;
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage, directly upstream of the decoder.
- Reads one 32-bit instruction per fetch as four little-endian bytes over the shared byte-wide memory port, with 1-cycle read latency.
- Presents `hit`/`pc`/`inst` to the decoder and holds them while the pipeline stalls.
- Handles redirects from branch/jump resolution by discarding the in-flight fetch and restarting at the target.

Parameters:
RESET_PC, 32'h0, first fetch address after reset
ADDR_WIDTH, 32, width of pc and memory address

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
rdy  in  1  global enable; 0 freezes all state (outputs hold)
stall  in  1  downstream cannot accept this cycle
jump_en  in  1  redirect request (one-cycle pulse)
jump_addr  in  ADDR_WIDTH  redirect target, word aligned
mem_grant  in  1  arbiter grants memory port to fetch this cycle
mem_din  in  8  byte returned by memory, one cycle after address
mem_a  out  ADDR_WIDTH  byte address requested (combinational)
hit  out  1  pc/inst valid; consumed when hit=1 and stall=0
pc  out  ADDR_WIDTH  address of presented instruction
inst  out  32  presented instruction

Behaviour:
- Reset (rst_n=0 at a rising edge, regardless of rdy):
  - state=FETCH, fetch_pc=RESET_PC, issue_cnt=0, recv_cnt=0, pending=0.
  - hit=0, pc=0, inst=0, byte buffer=0.
  - mem_a therefore reads RESET_PC.
  - Reset mid-fetch discards all partial bytes.
- rdy=0: no register changes. jump_en and mem_din are ignored that cycle; a byte arriving then is lost. The memory system must also stall whenever rdy=0.
- mem_a = fetch_pc + issue_cnt (issue_cnt 0..3). In HOLD it is still driven but no read is issued.
- State FETCH:
  - Issue occurs when mem_grant=1 and issue_cnt<4. Effect: issue_cnt+1, pending<=1. Otherwise pending<=0.
  - If pending=1, mem_din is byte recv_cnt of the instruction: stored into buffer[8*recv_cnt +: 8] and recv_cnt+1.
  - On the edge where recv_cnt==3 and pending=1:
    - inst <= {mem_din, buffer[23:0]}; pc <= fetch_pc; hit <= 1.
    - state <= HOLD; issue_cnt, recv_cnt <= 0.
  - Grant loss: no issue that cycle and no byte expected next cycle. The sequence resumes at the same byte index, with no duplicate or skipped bytes.
- State HOLD:
  - hit=1; pc and inst hold.
  - If stall=0: hit <= 0, fetch_pc <= pc + 4 (modulo 2^ADDR_WIDTH, wraps), state <= FETCH.
  - If stall=1: everything holds, for any number of cycles.
- Latency: with grant continuous, bytes are issued in cycles N..N+3 and hit is visible in cycle N+5. Steady-state throughput with no stall is one instruction per 6 cycles.
- Redirect (jump_en=1, rdy=1): highest priority, overrides stall, grant and byte completion.
  - Next edge: hit <= 0, fetch_pc <= jump_addr, issue_cnt, recv_cnt, pending <= 0, state <= FETCH.
  - A byte returning the cycle after a redirect is discarded; pending cleared ensures this.
  - A redirect in the same cycle as the 4th byte discards that instruction (no hit).
  - A redirect in HOLD drops the held instruction even if stall=1.
- Outputs are registered except mem_a. inst and pc are don't-care while hit=0 but must not change except as above.

Test Plan:
- Reset, RESET_PC=0, grant=1, memory bytes 0..3 = 13 05 10 00 -> mem_a 0,1,2,3 in cycles 0-3; hit=1 in cycle 5 with pc=0, inst=32'h00100513.
- Stall=1 for 3 cycles while hit=1 -> hit/pc/inst stable; after stall drops, hit=0 next cycle and mem_a=4; next instruction at pc=4.
- Grant dropped in the cycles addressing bytes 1 and 2 -> mem_a stays at the pending byte; hit delayed by exactly 2 cycles; inst correct.
- jump_en with jump_addr=32'h100 while 2 bytes captured -> no hit for the old pc; next hit has pc=32'h100 and the word from 0x100-0x103.
- jump_en on the edge of the 4th byte, and separately in HOLD with stall=1 -> hit=0 next cycle, fetch restarts at target.
- rdy=0 for 4 cycles mid-fetch, and rst_n=0 mid-fetch -> rdy: state frozen, resumes unchanged; reset: hit=0, mem_a=RESET_PC next cycle.
